// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
// Readback monitor for a multiplexed 7-segment display bus. It samples the
// one-hot digit scan and the active-low segment pattern, requires a run of
// STABLE identical qualified samples before a digit commits, and publishes a
// complete frame of packed BCD digits once every slot has been captured.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   sample_en    bus is evaluated only on cycles where this is 1
//   scan         one-hot digit select, bit i = digit i (0 = least significant)
//   hex          active-low segments, bit6 = g .. bit0 = a
//   clr_err      synchronous clear of the sticky error flags (set wins)
//   bcd          last complete frame, digit i in bits [4i+3:4i] (blank = 4'hF)
//   frame_valid  one-cycle pulse when bcd/blank_mask update
//   blank_mask   bit i set when digit i of the last frame was blank
//   bad_pat      sticky: an illegal segment pattern committed
//   bad_scan     sticky: a qualified sample had a non-one-hot scan
module seg7_scan_decoder #(
  parameter int unsigned NDIG   = 4,
  parameter int unsigned STABLE = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_en,
  input  logic [NDIG-1:0]   scan,
  input  logic [6:0]        hex,
  input  logic              clr_err,
  output logic [4*NDIG-1:0] bcd,
  output logic              frame_valid,
  output logic [NDIG-1:0]   blank_mask,
  output logic              bad_pat,
  output logic              bad_scan
);

  localparam logic [3:0] StableCnt = 4'(STABLE);

  // Returns {legal, blank, value}.
  function automatic logic [5:0] decode(input logic [6:0] p);
    logic [5:0] r;
    case (p)
      7'b1000000: r = {2'b10, 4'd0};
      7'b1111001: r = {2'b10, 4'd1};
      7'b0100100: r = {2'b10, 4'd2};
      7'b0110000: r = {2'b10, 4'd3};
      7'b0011001: r = {2'b10, 4'd4};
      7'b0010010: r = {2'b10, 4'd5};
      7'b0000010: r = {2'b10, 4'd6};
      7'b1111000: r = {2'b10, 4'd7};
      7'b0000000: r = {2'b10, 4'd8};
      7'b0011000: r = {2'b10, 4'd9};
      7'b1111111: r = {2'b11, 4'hF};
      default:    r = {2'b00, 4'h0};
    endcase
    return r;
  endfunction

  logic [3:0]        run_q, run_d;
  logic [NDIG-1:0]   prev_scan_q, prev_scan_d;
  logic [6:0]        prev_hex_q, prev_hex_d;
  logic [NDIG-1:0]   got_q, got_d;
  logic [4*NDIG-1:0] work_q, work_d;
  logic [NDIG-1:0]   wblank_q, wblank_d;

  logic       onehot;
  logic       same;
  logic       commit;
  logic       scan_err;
  logic       pat_err;
  logic       wr;
  logic       frame_done;
  logic [5:0] dec;

  assign onehot     = (scan != '0) && ((scan & (scan - NDIG'(1))) == '0);
  assign same       = (scan == prev_scan_q) && (hex == prev_hex_q);
  assign dec        = decode(hex);
  assign frame_done = &got_q;

  always_comb begin
    run_d       = run_q;
    prev_scan_d = prev_scan_q;
    prev_hex_d  = prev_hex_q;
    commit      = 1'b0;
    scan_err    = 1'b0;
    if (sample_en) begin
      if (!onehot) begin
        scan_err    = 1'b1;
        run_d       = '0;
        // Zero never matches a one-hot scan, so the next sample starts fresh.
        prev_scan_d = '0;
      end else if (same) begin
        // Saturated runs stay put, so a run commits only once.
        if (run_q < StableCnt) begin
          run_d  = run_q + 4'd1;
          commit = ((run_q + 4'd1) == StableCnt);
        end
      end else begin
        run_d       = 4'd1;
        prev_scan_d = scan;
        prev_hex_d  = hex;
        commit      = (StableCnt == 4'd1);
      end
    end
  end

  assign wr      = commit && dec[5];
  assign pat_err = commit && !dec[5];

  always_comb begin
    work_d   = work_q;
    wblank_d = wblank_q;
    // A completed frame clears got first; a commit in the same cycle then
    // counts toward the next frame.
    got_d    = frame_done ? '0 : got_q;
    if (wr) begin
      got_d = got_d | scan;
      for (int i = 0; i < int'(NDIG); i++) begin
        if (scan[i]) begin
          work_d[4*i +: 4] = dec[3:0];
          wblank_d[i]      = dec[4];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q       <= '0;
      prev_scan_q <= '0;
      prev_hex_q  <= '0;
      got_q       <= '0;
      work_q      <= '0;
      wblank_q    <= '0;
      bcd         <= '0;
      blank_mask  <= '0;
      frame_valid <= 1'b0;
      bad_pat     <= 1'b0;
      bad_scan    <= 1'b0;
    end else begin
      run_q       <= run_d;
      prev_scan_q <= prev_scan_d;
      prev_hex_q  <= prev_hex_d;
      got_q       <= got_d;
      work_q      <= work_d;
      wblank_q    <= wblank_d;
      frame_valid <= frame_done;
      if (frame_done) begin
        bcd        <= work_q;
        blank_mask <= wblank_q;
      end
      bad_pat  <= (bad_pat && !clr_err) || pat_err;
      bad_scan <= (bad_scan && !clr_err) || scan_err;
    end
  end

endmodule
